bus_arbiter_4x64: RTL and testbench

- Round-robin arbiter and sequencer sharing one 64-bit datapath between four requesters.
- Drives the select of an internal mux_64x4x1 to pick the granted requester's data.
- Registers the selected beat into a valid/ready output stage.
- Supports burst ownership with a bounded burst length and an abandon timeout, so no requester can starve the others.

---
 rtl/bus_arb_pkg.sv | 19 +
 rtl/mux_64x4x1.sv | 23 ++
 rtl/rr_pick4.sv | 27 ++
 rtl/bus_arbiter_4x64.sv | 169 ++++++++++++++++
 tb/tb_bus_arbiter_4x64.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the four-requester 64-bit bus arbiter.
// Owner and pointer indices are two-bit requester numbers.
package bus_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 64;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  typedef logic [1:0] req_idx_t;

  function automatic logic [NUM_REQ-1:0] onehot4(input req_idx_t idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux_64x4x1.sv
// 64-bit four-input mux. sel=0 picks D, sel=1 picks C, sel=2 picks B,
// and sel=3 picks A.
module mux_64x4x1 (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [63:0] c_i,
  input  logic [63:0] d_i,
  input  logic [1:0]  sel_i,
  output logic [63:0] y_o
);

  always_comb begin
    y_o = d_i;
    case (sel_i)
      2'd0:    y_o = d_i;
      2'd1:    y_o = c_i;
      2'd2:    y_o = b_i;
      2'd3:    y_o = a_i;
      default: y_o = d_i;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker. It returns the first set request found
// when scanning from ptr upward, wrapping modulo 4.
module rr_pick4
  import bus_arb_pkg::*;
(
  input  logic [3:0] req_i,
  input  req_idx_t   ptr_i,
  output req_idx_t   winner_o,
  output logic       found_o
);

  req_idx_t idx;

  always_comb begin
    winner_o = ptr_i;
    found_o  = 1'b0;
    idx      = ptr_i;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr_i + req_idx_t'(i);
      if (!found_o && req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_4x64.sv
// Round-robin arbiter that shares one 64-bit datapath among four requesters.
// It supports bounded bursts, an abandon timeout, and a registered valid/ready output.
//
//   state | meaning
//   IDLE  | no owner; arbitrate among pending requests from ptr
//   BUSY  | owner holds the datapath; beats taken when output has space
module bus_arbiter_4x64
  import bus_arb_pkg::*;
#(
  parameter int MAX_BURST      = 16,
  parameter int ABANDON_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  last,
  input  logic [63:0] in_data0,
  input  logic [63:0] in_data1,
  input  logic [63:0] in_data2,
  input  logic [63:0] in_data3,
  output logic [3:0]  grant,
  output logic [3:0]  beat_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [1:0]  out_src,
  output logic        out_last
);

  localparam logic [8:0] MAX_B   = 9'(MAX_BURST);
  localparam logic [7:0] ABANDON = 8'(ABANDON_CYCLES);

  arb_state_t  state_q, state_d;
  req_idx_t    owner_q, owner_d;
  req_idx_t    ptr_q, ptr_d;
  logic [3:0]  grant_q, grant_d;
  logic [8:0]  beat_q, beat_d;
  logic [7:0]  aband_q, aband_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;
  req_idx_t    out_src_q, out_src_d;
  logic        out_last_q, out_last_d;

  req_idx_t    win;
  logic        found;
  logic [63:0] mux_y;
  logic        space;
  logic        own_req;
  logic        own_last;
  logic [8:0]  beat_inc;
  logic [7:0]  aband_inc;
  logic        hit_max;
  logic        burst_end;
  logic [3:0]  ack_vec;

  rr_pick4 u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (win),
    .found_o  (found)
  );

  mux_64x4x1 u_mux (
    .a_i   (in_data3),
    .b_i   (in_data2),
    .c_i   (in_data1),
    .d_i   (in_data0),
    .sel_i (owner_q),
    .y_o   (mux_y)
  );

  assign space     = ~out_valid_q | out_ready;
  assign own_req   = req[owner_q];
  assign own_last  = last[owner_q];
  assign beat_inc  = beat_q + 9'd1;
  assign aband_inc = aband_q + 8'd1;
  assign hit_max   = (beat_inc == MAX_B);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    beat_d      = beat_q;
    aband_d     = aband_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;
    ack_vec     = '0;
    burst_end   = 1'b0;

    // A consumed beat empties the stage unless a new beat replaces it below.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          owner_d = win;
          grant_d = onehot4(win);
          beat_d  = '0;
          aband_d = '0;
        end
      end
      BUSY: begin
        if (own_req && space) begin
          ack_vec     = onehot4(owner_q);
          out_data_d  = mux_y;
          out_src_d   = owner_q;
          out_valid_d = 1'b1;
          out_last_d  = own_last | hit_max;
          beat_d      = beat_inc;
          aband_d     = '0;
          burst_end   = own_last | hit_max;
        end else if (!own_req) begin
          // Stalls from backpressure do not count toward abandon.
          aband_d   = aband_inc;
          burst_end = (aband_inc == ABANDON);
        end
        if (burst_end) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = owner_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      beat_q      <= '0;
      aband_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      beat_q      <= beat_d;
      aband_q     <= aband_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
    end
  end

  assign grant     = grant_q;
  assign beat_ack  = ack_vec;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_bus_arbiter_4x64.sv
// Directed bench for bus_arbiter_4x64 with MAX_BURST=4 and ABANDON_CYCLES=8.
// Expected beats are queued as they are issued, and a monitor checks them on each handshake.
module tb_bus_arbiter_4x64;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, last;
  logic [63:0] din [4];
  logic [3:0]  grant, beat_ack;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic [1:0]  out_src;
  logic        out_last;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  src;
    logic        lst;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  bus_arbiter_4x64 #(.MAX_BURST(4), .ABANDON_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .last      (last),
    .in_data0  (din[0]),
    .in_data1  (din[1]),
    .in_data2  (din[2]),
    .in_data3  (din[3]),
    .grant     (grant),
    .beat_ack  (beat_ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [1:0] s, input logic l);
    beat_t b;
    b.data = d;
    b.src  = s;
    b.lst  = l;
    exp_q.push_back(b);
  endtask

  // Monitor: the handshake completes on the next rising edge
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected_beat actual=%h required=none", out_data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("mon_data", out_data, e.data);
        chk("mon_src", 64'(out_src), 64'(e.src));
        chk("mon_last", 64'(out_last), 64'(e.lst));
      end
    end
  end

  initial begin
    logic [3:0] g;
    reset = 1'b0;
    req = '0;
    last = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = '0;
    step();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_data", out_data, 64'h0);
    chk("rst_src", 64'(out_src), 64'h0);
    chk("rst_last", 64'(out_last), 64'h0);
    reset = 1'b1;
    step();

    // Single beat with last from requester 0
    req = 4'b0001; last = 4'b0001; din[0] = 64'hA5;
    settle();
    chk("t1_idle_ack", 64'(beat_ack), 64'h0);
    step();
    chk("t1_grant", 64'(grant), 64'h1);
    chk("t1_ack", 64'(beat_ack), 64'h1);
    push(64'hA5, 2'd0, 1'b1);
    step();
    req = '0; last = '0;
    chk("t1_grant_off", 64'(grant), 64'h0);
    chk("t1_valid", 64'(out_valid), 64'h1);
    step(); step();

    // Round robin from ptr=0 with all four requesting
    reset = 1'b0; step(); reset = 1'b1;
    req = 4'b1111; last = 4'b1111;
    for (int i = 0; i < 4; i++) din[i] = 64'h100 + 64'(i);
    settle();
    for (int i = 0; i < 5; i++) begin
      chk("rr_idle_grant", 64'(grant), 64'h0);
      step();
      g = 4'b0001 << (i % 4);
      chk("rr_grant", 64'(grant), 64'(g));
      chk("rr_ack", 64'(beat_ack), 64'(g));
      push(din[i % 4], 2'(i % 4), 1'b1);
      step();
    end
    req = '0; last = '0;
    step(); step();

    // Burst capped at MAX_BURST=4 (ptr=1)
    req = 4'b0100; last = '0; din[2] = 64'd1;
    settle();
    chk("mb_idle", 64'(grant), 64'h0);
    step();
    for (int j = 1; j <= 4; j++) begin
      din[2] = 64'(j);
      settle();
      chk("mb_grant", 64'(grant), 64'h4);
      chk("mb_ack", 64'(beat_ack), 64'h4);
      push(64'(j), 2'd2, (j == 4));
      step();
    end
    chk("mb_released", 64'(grant), 64'h0);
    req = 4'b1100; last = 4'b1000; din[3] = 64'h33; din[2] = 64'd5;
    step();
    chk("mb_next_owner", 64'(grant), 64'h8);
    push(64'h33, 2'd3, 1'b1);
    step();
    req = 4'b0100; last = 4'b0100;
    settle();
    chk("mb_rearb_idle", 64'(grant), 64'h0);
    step();
    chk("mb_beat5_grant", 64'(grant), 64'h4);
    push(64'd5, 2'd2, 1'b1);
    step();
    req = '0; last = '0;
    step(); step();

    // Abandon: requester 1 drops after one beat (ptr=3)
    req = 4'b0010; last = '0; din[1] = 64'h11;
    step();
    chk("ab_grant", 64'(grant), 64'h2);
    push(64'h11, 2'd1, 1'b0);
    step();
    req = '0;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("ab_hold", 64'(grant), 64'h2);
    end
    step();
    chk("ab_release", 64'(grant), 64'h0);
    chk("ab_no_valid", 64'(out_valid), 64'h0);
    step();

    // Backpressure: five stall cycles hold the beat and the grant (ptr=2)
    req = 4'b0100; last = '0; din[2] = 64'h1234; out_ready = 1'b1;
    step();
    chk("bp_grant", 64'(grant), 64'h4);
    chk("bp_ack0", 64'(beat_ack), 64'h4);
    push(64'h1234, 2'd2, 1'b0);
    out_ready = 1'b0;
    step();
    din[2] = 64'h5678;
    settle();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(out_valid), 64'h1);
      chk("bp_data", out_data, 64'h1234);
      chk("bp_ack", 64'(beat_ack), 64'h0);
      chk("bp_grant_hold", 64'(grant), 64'h4);
      step();
    end
    out_ready = 1'b1; last = 4'b0100;
    settle();
    chk("bp_ack_resume", 64'(beat_ack), 64'h4);
    push(64'h5678, 2'd2, 1'b1);
    step();
    req = '0; last = '0;
    chk("bp_release", 64'(grant), 64'h0);
    step(); step();

    // Async reset mid-burst (ptr=3)
    req = 4'b0010; last = '0; din[1] = 64'hDEAD;
    step();
    step();
    chk("mr_pre_valid", 64'(out_valid), 64'h1);
    chk("mr_pre_data", out_data, 64'hDEAD);
    reset = 1'b0;
    #1;
    chk("mr_grant", 64'(grant), 64'h0);
    chk("mr_valid", 64'(out_valid), 64'h0);
    chk("mr_data", out_data, 64'h0);
    req = 4'b1111; last = 4'b1111;
    for (int i = 0; i < 4; i++) din[i] = 64'h200 + 64'(i);
    #1;
    reset = 1'b1;
    step();
    chk("mr_first_prio", 64'(grant), 64'h1);
    push(64'h200, 2'd0, 1'b1);
    step();
    req = '0; last = '0;
    step(); step(); step();

    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
